// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM and ALU control.
// Optional feature macro: MC_JUMP_EN (compiles the JUMP state for opcode 0110).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMM_EX = 4'd9,
    S_IMM_WB = 4'd10
`ifdef MC_JUMP_EN
    ,
    S_JUMP   = 4'd11
`endif
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_SLTI  = 4'b0101;
  localparam logic [3:0] OP_J     = 4'b0110;

  localparam logic [1:0] ALU_R   = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLT = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the FSM has a path for; J only when jumps are built in.
  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI: legal = 1'b1;
`ifdef MC_JUMP_EN
      OP_J: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational Moore output decode for the multicycle control FSM.
// Optional feature macro: MC_JUMP_EN (adds the JUMP state outputs).
module mc_output_decode
  import mc_pkg::*;
(
  input  state_e     state,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       illegal_op
);

  state_e st;

  // Map state (treated as FETCH while in reset) to datapath controls; reset masks all write enables.
  always_comb begin
    st            = rst ? S_FETCH : state;
    alu_op        = ALU_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    iord          = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    illegal_op    = 1'b0;
    case (st)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_BOFF;
        illegal_op = !op_is_legal(opcode);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_op    = ALU_R;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IMM_WB: begin
        reg_write = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
`endif
      default: ;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle 16-bit MIPS datapath.
// Optional feature macro: MC_JUMP_EN (opcode 0110 executes as J; otherwise illegal).
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       illegal_op
);

  state_e state_q, state_d;

  // State register; synchronous reset returns to FETCH and aborts any instruction.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = S_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_IMM_EX;
`ifdef MC_JUMP_EN
          OP_J:             state_d = S_JUMP;
`endif
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_IMM_EX: state_d = S_IMM_WB;
      S_IMM_WB: state_d = S_FETCH;
`ifdef MC_JUMP_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .state         (state_q),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .iord          (iord),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .illegal_op    (illegal_op)
  );

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style main control FSM for the multicycle 16-bit MIPS datapath. It sits directly upstream of ALU control and produces the 2-bit ALUOp that ALU control expands, together with every datapath enable and mux select. It steps each instruction through fetch, decode, execute, memory and writeback. A memory-ready handshake stretches the fetch and data-memory states.

## Interface
Parameters:
- none. Widths are fixed by the ISA.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  instr[15:12] from the external instruction register; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- alu_op  out  2  to ALU control: 00 R-type (funct), 01 subtract (BEQ), 10 SLTI, 11 add.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 1, 10 = sign-extended immediate, 11 = branch offset.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write  out  1 each  datapath enables.
- iord, mem_to_reg, reg_dst  out  1 each  mux selects.
- illegal_op  out  1  one-cycle pulse when an undefined opcode is decoded.

## Operation
- Opcodes: 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 0101 SLTI, 0110 J. All others are illegal.
- Default for every output not listed in a state is 0, except alu_op, whose default is 11.
- States, with asserted outputs and transitions:
  - FETCH: mem_read, alu_src_b=01. ir_write and pc_write equal mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: alu_src_b=11 (branch target precompute). Next state by opcode:
    - LW or SW: MEMADR
    - R-type: EXEC
    - BEQ: BRANCH
    - ADDI or SLTI: IMM_EX
    - J: JUMP
    - illegal: FETCH, with illegal_op=1 in DECODE.
  - MEMADR: alu_src_a=1, alu_src_b=10. Goes to MEMRD (LW) or MEMWR (SW).
  - MEMRD: mem_read, iord. Waits for mem_ready, then goes to MEMWB.
  - MEMWB: reg_write, mem_to_reg, reg_dst=0. Goes to FETCH.
  - MEMWR: mem_write, iord. Waits for mem_ready, then goes to FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=00. Goes to ALUWB.
  - ALUWB: reg_write, reg_dst=1. Goes to FETCH.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond, pc_source=01. Goes to FETCH.
  - IMM_EX: alu_src_a=1, alu_src_b=10. alu_op=10 if the opcode is SLTI, else 11. Goes to IMM_WB.
  - IMM_WB: reg_write, reg_dst=0. Goes to FETCH.
  - JUMP: pc_write, pc_source=10. Goes to FETCH.
- opcode is re-read combinationally in DECODE, MEMADR and IMM_EX. The datapath holds the IR stable because ir_write is asserted only in FETCH.

## Timing
- Reset: with rst=1 at an edge, the state becomes FETCH.
  - While rst=1, pc_write, pc_write_cond, ir_write, mem_write, reg_write and illegal_op are forced to 0.
  - All other outputs show their FETCH values.
- Reset mid-instruction aborts the instruction at the next edge. No writeback occurs.
- Outputs are a combinational decode of the state register, except that ir_write and pc_write in FETCH also depend on mem_ready. Next state is registered.
- Cycle counts with mem_ready held at 1:
  - J and BEQ: 3
  - R-type, ADDI, SLTI and SW: 4
  - LW: 5
  - Illegal opcode: 2
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. mem_read, mem_write and iord stay level for the whole wait.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- The state register never holds an unused encoding. Any unused encoding must go to FETCH on the next edge.

## Configuration
- MC_JUMP_EN defined: opcode 0110 goes from DECODE to JUMP, as described above.
- MC_JUMP_EN undefined: the JUMP state is not compiled. Opcode 0110 is treated as illegal (illegal_op pulse, return to FETCH), and pc_source never equals 10.

## Structure
- A shared package mc_pkg holds:
  - the state enum (4-bit encoding)
  - the opcode constants
  - the alu_op constants (ALU_R=00, ALU_SUB=01, ALU_SLT=10, ALU_ADD=11), which ALU control also consumes
  - the alu_src_b and pc_source encodings.
- The natural sub-module is mc_output_decode: a purely combinational mapping from state, opcode and mem_ready to the outputs. The top module keeps the state register and the next-state logic.

## Test plan
- Reset with mem_ready=1, then R-type (opcode 0000): states FETCH, DECODE, EXEC, ALUWB, FETCH. alu_op=00 in EXEC; reg_write=1 and reg_dst=1 in ALUWB only.
- LW with mem_ready=0 for 2 cycles in MEMRD: 7 cycles in total. mem_read=1 and iord=1 held for 3 cycles, then reg_write=1 with mem_to_reg=1.
- SLTI (0101) and then ADDI (0100): alu_op is 10 and 11 respectively in IMM_EX. reg_write=1 in IMM_WB with reg_dst=0.
- BEQ: a 3-cycle instruction. pc_write_cond=1, pc_source=01 and alu_op=01 in BRANCH; reg_write is never asserted.
- Opcode 1111, and also 0110 with MC_JUMP_EN undefined: illegal_op is a 1-cycle pulse in DECODE and the FSM returns to FETCH. With MC_JUMP_EN defined, 0110 gives pc_write=1 and pc_source=10.
- rst asserted in MEMWR while mem_ready=0: mem_write is 0 in the same cycle, and the state is FETCH after the edge.
